// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the UART transmit path: bit/byte aliases, FSM state enum and parity helper.
// PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_pkg;

  typedef logic       Bit_t;
  typedef logic [7:0] Byte_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } Uart_tx_state_t;

  function automatic Bit_t even_parity(input Byte_t b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 (DIV = ClkFrequency/Baud, truncated) and pulses tick on the wrap.
// A clear restarts the period from zero on the next cycle.
module uart_baud_tick #(
  parameter int unsigned ClkFrequency = 60000000,
  parameter int unsigned Baud         = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned Div  = ClkFrequency / Baud;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(Div - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small power-of-two FIFO; 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Back-to-back frames are sent without idle gap while the FIFO holds data.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned ClkFrequency = 60000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tx_start,
  input  Byte_t tx_data,
  output logic  tx_busy,
  output logic  tx_empty,
  output logic  txd
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  Byte_t           fifo_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  Uart_tx_state_t  state_q, state_d;
  Byte_t           shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            txd_q, txd_d;

  logic            push, pop, fifo_nonempty, tick;

  uart_baud_tick #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (pop),
    .tick  (tick)
  );

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign tx_busy       = (count_q == CntW'(FifoDepth));
  assign fifo_nonempty = (count_q != '0);
  assign push          = tx_start && !tx_busy;
  assign tx_empty      = !fifo_nonempty && (state_q == ST_IDLE);
  assign txd           = txd_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the current state, so txd trails the FSM by one cycle uniformly.
  always_comb begin
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = even_parity(shift_q);
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter ClkFrequency, default 60000000, input clock frequency in Hz.
REQ-002 SHALL have parameter Baud, default 115200, line bit rate.
REQ-003 SHALL have parameter FifoDepth, default 4, transmit FIFO entries; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  the only clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port tx_start  input  1  push request for tx_data.
REQ-007 SHALL have port tx_data  input  8 (Byte_t)  byte to enqueue.
REQ-008 SHALL have port tx_busy  output  1  FIFO full; pushes are refused.
REQ-009 SHALL have port tx_empty  output  1  FIFO empty and the shifter is in IDLE.
REQ-010 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-011 SHALL use a bit period DIV = ClkFrequency/Baud, truncated (520 cycles at the defaults).
REQ-012 SHALL write tx_data into the FIFO on a posedge where tx_start=1 and tx_busy=0.
REQ-013 SHALL silently drop a push while tx_busy=1; contents are unchanged and no error is flagged.
REQ-014 SHALL derive tx_busy from the registered count (count==FifoDepth); a same-cycle pop does not admit a push when full.
REQ-015 SHALL run the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head into the shift register, clear the baud counter and enter START.
REQ-017 SHALL drive txd low from the second posedge after an accepted push into an empty FIFO with the FSM in IDLE.
REQ-018 SHALL hold each state for exactly DIV cycles: START (txd=0), then DATA for 8 bits LSB first, then PARITY if enabled, then STOP (txd=1).
REQ-019 SHALL count the baud counter 0..DIV-1 and wrap to 0; the state or bit advances on the wrap.
REQ-020 SHALL, at the end of STOP, go directly to START with the next popped byte if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-021 SHALL allow push and pop in the same cycle; the count is unchanged and both pointers advance modulo FifoDepth.
REQ-022 SHALL register txd so it is glitch-free; txd=1 in IDLE.
REQ-023 SHALL assert tx_empty only when count==0 and the FSM is in IDLE.

Reset
REQ-024 SHALL, on rst=1 at a posedge: FSM=IDLE, count=0, read/write pointers=0, baud counter=0, txd=1, tx_busy=0, tx_empty=1.
REQ-025 SHALL, on reset mid-frame, abort the frame (txd=1 the next cycle) and discard the queued bytes.
REQ-026 SHALL give rst priority over a simultaneous tx_start.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state after DATA driving even parity (XOR of the 8 data bits) for DIV cycles; frame = 11 bits.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely; DATA goes to STOP and frame = 10 bits.

Structure
REQ-029 SHALL place Bit_t, Byte_t and the Uart_tx_state_t enum in the shared peripheral package header.
REQ-030 SHALL implement the baud counter as sub-module uart_baud_tick (inputs clk, rst, clear; output tick), parameterised by ClkFrequency and Baud.
REQ-031 SHALL keep the FIFO inline as a register array with pointers and a count.

Verification
REQ-032 SHALL check: reset, then push 0x55 -> txd falls at edge 2, bits 1,0,1,0,1,0,1,0 (LSB first) each 520 cycles, stop high, frame 5200 cycles (no parity), then tx_empty=1.
REQ-033 SHALL check: push 0x01,0x02,0x03,0x04 on consecutive cycles -> tx_busy=0 throughout (first byte already popped), four frames back-to-back with no idle gap, txd stays high after the last stop.
REQ-034 SHALL check: with the FIFO full (shifter busy, 4 queued), push 0xAA -> tx_busy=1, byte dropped, only the 5 previously accepted bytes appear on txd.
REQ-035 SHALL check: push while the FSM pops at the end of a STOP bit in a full FIFO -> push refused; with 3 queued instead, push accepted and count unchanged.
REQ-036 SHALL check: assert rst at cycle 2000 of a frame carrying 0xC3 -> txd=1 next cycle, tx_empty=1, no further frames.
REQ-037 SHALL check: with UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 (even), frame 5720 cycles; push 0x03 -> parity bit 0.
